// File: rtl/disp_pkg.sv
// Shared display-path definitions: pipeline latency, pixel width and the
// pixel-output sequencer state encoding.
`timescale 1ns/1ps
package disp_pkg;

    // Input-to-output latency of the pixel output stage in DCLK cycles.
    // The RGB path is built for exactly two stages.
    localparam int PIPE_DLY = 2;

    // Pixel word layout {R[7:0], G[7:0], B[7:0]}.
    localparam int PIXW = 24;

    // Width of the starved-pixel counter.
    localparam int UCNT_W = 16;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

endpackage

// File: rtl/disp_pixout_if.sv
// Pixel FIFO read-side bus between the FIFO and the pixel output stage.
`timescale 1ns/1ps
interface disp_pixout_if #(
    parameter int PIXW = disp_pkg::PIXW
);
    logic [PIXW-1:0] FIFO_DOUT;
    logic            FIFO_EMPTY;
    logic            FIFO_RD;
    logic            FIFO_CLR;

    // Pixel output stage: issues reads and flush requests.
    modport master (
        input  FIFO_DOUT,
        input  FIFO_EMPTY,
        output FIFO_RD,
        output FIFO_CLR
    );

    // FIFO: supplies data and the empty flag.
    modport slave (
        output FIFO_DOUT,
        output FIFO_EMPTY,
        input  FIFO_RD,
        input  FIFO_CLR
    );
endinterface

// File: rtl/disp_dly.sv
// N-stage shift register with a per-bit reset value; used for the
// DE / HSYNC / VSYNC timing delay lines.
`timescale 1ns/1ps
module disp_dly #(
    parameter int           N       = 2,
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         DCLK,
    input  logic         DRST_X,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] sr [N];

    // Shift the input through N stages; reset loads every stage with RST_VAL.
    always_ff @(posedge DCLK or negedge DRST_X) begin
        if (!DRST_X) begin
            for (int i = 0; i < N; i++) sr[i] <= RST_VAL;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[N-1];

endmodule

// File: rtl/disp_pixout.sv
// Pixel output stage: pulls pixels from the FIFO while the sync generator
// asks for them, aligns RGB with the delayed panel timing, blanks starved
// pixels, and tracks FIFO underflow per frame.
`timescale 1ns/1ps
module disp_pixout #(
    parameter int PIPE_DLY = disp_pkg::PIPE_DLY,
    parameter int PIXW     = disp_pkg::PIXW
) (
    input  logic                 DCLK,
    input  logic                 DRST_X,
    input  logic                 DISP_ON,
    input  logic                 DSP_preDE,
    input  logic                 HSYNC_X_IN,
    input  logic                 VSYNC_X_IN,
    input  logic                 VRSTART,
    disp_pixout_if.master        fifo,
    output logic [7:0]           DSP_R,
    output logic [7:0]           DSP_G,
    output logic [7:0]           DSP_B,
    output logic                 DSP_DE,
    output logic                 DSP_HSYNC_X,
    output logic                 DSP_VSYNC_X,
    output logic                 UNDERFLOW,
    output logic [15:0]          UNDER_CNT
);
    import disp_pkg::*;

    state_t            state, state_nxt;
    logic              fifo_rd;
    logic              starve;
    logic              clr_nxt;
    logic              fifo_clr_q;
    logic              vld_p0;
    logic [PIXW-1:0]   rgb_p1;
    logic [15:0]       under_cnt_q;
    logic              underflow_q;
    logic [2:0]        tim_in, tim_out;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next state, read strobe, starved-pixel detect and flush request.
    always_comb begin
        state_nxt = state;
        fifo_rd   = (state == ST_RUN) && DSP_preDE && !fifo.FIFO_EMPTY;
        starve    = DSP_preDE && DISP_ON && !fifo_rd &&
                    (state == ST_RUN || state == ST_RESYNC);
        case (state)
            ST_WAIT:   if (VRSTART) state_nxt = ST_RUN;
            ST_RUN:    if (DSP_preDE && fifo.FIFO_EMPTY) state_nxt = ST_RESYNC;
            ST_RESYNC: if (VRSTART) state_nxt = ST_RUN;
            default:   state_nxt = ST_WAIT;
        endcase
        // Display off overrides everything, including a VRSTART in WAIT.
        if (!DISP_ON) state_nxt = ST_WAIT;
        // Flush on entering RESYNC, or WAIT from elsewhere; reset never flushes.
        clr_nxt = (state_nxt != state) &&
                  (state_nxt == ST_WAIT || state_nxt == ST_RESYNC);
    end

    // State register and one-cycle flush pulse.
    always_ff @(posedge DCLK or negedge DRST_X) begin
        if (!DRST_X) begin
            state      <= ST_WAIT;
            fifo_clr_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            fifo_clr_q <= clr_nxt;
        end
    end

    assign fifo.FIFO_RD  = fifo_rd;
    assign fifo.FIFO_CLR = fifo_clr_q;

    // ---- stage p0: read issued last cycle, FIFO_DOUT now valid ----
    // ---- stage p1: registered RGB, black unless a real pixel was read ----
    // Reads imply preDE, so a blank p0 slot also covers delayed DE low.
    always_ff @(posedge DCLK or negedge DRST_X) begin
        if (!DRST_X) begin
            vld_p0 <= 1'b0;
            rgb_p1 <= '0;
        end else begin
            vld_p0 <= fifo_rd;
            rgb_p1 <= vld_p0 ? fifo.FIFO_DOUT : '0;
        end
    end

    assign DSP_R = rgb_p1[23:16];
    assign DSP_G = rgb_p1[15:8];
    assign DSP_B = rgb_p1[7:0];

    // Starved-pixel counter and per-frame sticky underflow flag.
    always_ff @(posedge DCLK or negedge DRST_X) begin
        if (!DRST_X) begin
            under_cnt_q <= '0;
            underflow_q <= 1'b0;
        end else if (VRSTART) begin
            under_cnt_q <= starve ? 16'd1 : 16'd0;
            underflow_q <= (under_cnt_q != 16'd0) || starve;
        end else if (starve) begin
            under_cnt_q <= sat_inc(under_cnt_q);
        end
    end

    assign UNDER_CNT = under_cnt_q;
    assign UNDERFLOW = underflow_q;

    // Panel timing runs regardless of FSM state and DISP_ON.
    assign tim_in = {DSP_preDE, HSYNC_X_IN, VSYNC_X_IN};

    disp_dly #(
        .N       (PIPE_DLY),
        .W       (3),
        .RST_VAL (3'b011)
    ) u_tim_dly (
        .DCLK   (DCLK),
        .DRST_X (DRST_X),
        .din    (tim_in),
        .dout   (tim_out)
    );

    assign DSP_DE      = tim_out[2];
    assign DSP_HSYNC_X = tim_out[1];
    assign DSP_VSYNC_X = tim_out[0];

endmodule

// File: tb/tb_disp_pixout.sv
// Directed bench for disp_pixout: FSM step table plus full-line, underflow,
// display-off, mid-frame reset and counter saturation sequences.
`timescale 1ns/1ps
module tb_disp_pixout;

    logic        DCLK = 1'b0;
    logic        DRST_X, DISP_ON, DSP_preDE, HSYNC_X_IN, VSYNC_X_IN, VRSTART;
    logic [7:0]  DSP_R, DSP_G, DSP_B;
    logic        DSP_DE, DSP_HSYNC_X, DSP_VSYNC_X, UNDERFLOW;
    logic [15:0] UNDER_CNT;

    disp_pixout_if #(.PIXW(24)) fif();

    disp_pixout dut (
        .DCLK(DCLK), .DRST_X(DRST_X), .DISP_ON(DISP_ON), .DSP_preDE(DSP_preDE),
        .HSYNC_X_IN(HSYNC_X_IN), .VSYNC_X_IN(VSYNC_X_IN), .VRSTART(VRSTART),
        .fifo(fif), .DSP_R(DSP_R), .DSP_G(DSP_G), .DSP_B(DSP_B),
        .DSP_DE(DSP_DE), .DSP_HSYNC_X(DSP_HSYNC_X), .DSP_VSYNC_X(DSP_VSYNC_X),
        .UNDERFLOW(UNDERFLOW), .UNDER_CNT(UNDER_CNT)
    );

    always #5 DCLK = ~DCLK;

    // FIFO model: pixels of a load are numbered 1..n; clear drops the rest.
    bit          use_model = 1'b0;
    logic        tb_empty  = 1'b1;
    int          wr_total  = 0;
    int          rd_count  = 0;
    int          line_base = 0;
    logic [23:0] model_dout = '0;

    assign fif.FIFO_EMPTY = use_model ? (rd_count >= wr_total) : tb_empty;
    assign fif.FIFO_DOUT  = use_model ? model_dout : 24'h0;

    always @(posedge DCLK) begin
        if (fif.FIFO_CLR) begin
            rd_count <= wr_total;
        end else if (fif.FIFO_RD && rd_count < wr_total) begin
            model_dout <= 24'(rd_count - line_base + 1);
            rd_count   <= rd_count + 1;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load_fifo(input int n);
        line_base = rd_count;
        wr_total  = rd_count + n;
    endtask

    task automatic do_reset();
        @(negedge DCLK);
        DRST_X = 1'b0; DSP_preDE = 1'b0; VRSTART = 1'b0;
        HSYNC_X_IN = 1'b1; VSYNC_X_IN = 1'b1;
        @(negedge DCLK);
        DRST_X = 1'b1;
        load_fifo(0);
    endtask

    task automatic pulse_vr();
        @(negedge DCLK);
        VRSTART = 1'b1; DSP_preDE = 1'b0;
        @(negedge DCLK);
        VRSTART = 1'b0;
    endtask

    // History of timing inputs so outputs can be checked two cycles later.
    logic de_h [0:2047];
    logic hs_h [0:2047];
    logic vs_h [0:2047];

    // One frame-start plus a line of de_len preDE cycles, total cycles long.
    // Pixels 1..lim are expected on DSP_DE, black afterwards.
    task automatic run_line(input int de_len, input int total, input int npix,
                            input int drop_at, output int bad_rgb, output int bad_tim,
                            output int clr_cnt, output int rd_after_drop);
        int lim, d;
        logic [23:0] exp_rgb;
        bad_rgb = 0; bad_tim = 0; clr_cnt = 0; rd_after_drop = 0;
        lim = (drop_at >= 0 && drop_at + 1 < npix) ? drop_at + 1 : npix;
        @(negedge DCLK);
        DISP_ON = 1'b1; VRSTART = 1'b1; DSP_preDE = 1'b0;
        for (int c = 0; c < total; c++) begin
            @(negedge DCLK);
            VRSTART    = 1'b0;
            DSP_preDE  = (c < de_len);
            HSYNC_X_IN = ((c % 16) < 12);
            VSYNC_X_IN = ((c % 64) < 60);
            if (drop_at >= 0 && c >= drop_at) DISP_ON = 1'b0;
            de_h[c] = DSP_preDE; hs_h[c] = HSYNC_X_IN; vs_h[c] = VSYNC_X_IN;
            clr_cnt += int'(fif.FIFO_CLR);
            if (drop_at >= 0 && c == drop_at + 1) begin
                #1 rd_after_drop = int'(fif.FIFO_RD);
            end
            if (c >= 2) begin
                d = c - 2;
                exp_rgb = (de_h[d] && d < lim) ? 24'(d + 1) : 24'h0;
                if ({DSP_R, DSP_G, DSP_B} !== exp_rgb) begin
                    if (bad_rgb == 0)
                        $display("FAIL line_rgb cycle=%0d actual=%h required=%h",
                                 c, {DSP_R, DSP_G, DSP_B}, exp_rgb);
                    bad_rgb++;
                end
                if (DSP_DE !== de_h[d] || DSP_HSYNC_X !== hs_h[d] || DSP_VSYNC_X !== vs_h[d])
                    bad_tim++;
            end
        end
        DSP_preDE = 1'b0; HSYNC_X_IN = 1'b1; VSYNC_X_IN = 1'b1;
    endtask

    typedef struct {
        bit          on, de, emp, vr;
        bit          exp_rd, exp_clr;
        logic [15:0] exp_cnt;
        bit          exp_uf;
    } vec_t;

    vec_t tbl [16];

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "time limit");
    end

    initial begin : main
        int bad_rgb, bad_tim, clr_cnt, rd_ad;

        //           on de emp vr  rd clr cnt    uf
        tbl[0]  = '{1, 1, 0, 0,  0, 0, 16'd0, 0};
        tbl[1]  = '{1, 0, 0, 1,  0, 0, 16'd0, 0};
        tbl[2]  = '{1, 1, 0, 0,  1, 0, 16'd0, 0};
        tbl[3]  = '{1, 0, 1, 0,  0, 0, 16'd0, 0};
        tbl[4]  = '{1, 1, 1, 0,  0, 1, 16'd1, 0};
        tbl[5]  = '{1, 1, 0, 0,  0, 0, 16'd2, 0};
        tbl[6]  = '{1, 0, 0, 1,  0, 0, 16'd0, 1};
        tbl[7]  = '{1, 1, 0, 0,  1, 0, 16'd0, 1};
        tbl[8]  = '{0, 1, 0, 0,  1, 1, 16'd0, 1};
        tbl[9]  = '{0, 1, 0, 1,  0, 0, 16'd0, 0};
        tbl[10] = '{1, 1, 0, 0,  0, 0, 16'd0, 0};
        tbl[11] = '{1, 0, 0, 1,  0, 0, 16'd0, 0};
        tbl[12] = '{1, 1, 1, 1,  0, 1, 16'd1, 1};
        tbl[13] = '{1, 0, 1, 0,  0, 0, 16'd1, 1};
        tbl[14] = '{0, 0, 1, 0,  0, 1, 16'd1, 1};
        tbl[15] = '{0, 0, 1, 0,  0, 0, 16'd1, 1};

        DRST_X = 1'b0; DISP_ON = 1'b0; DSP_preDE = 1'b0; VRSTART = 1'b0;
        HSYNC_X_IN = 1'b0; VSYNC_X_IN = 1'b0;
        repeat (3) @(negedge DCLK);

        chk("rst_rgb",   {DSP_R, DSP_G, DSP_B}, 0);
        chk("rst_de",    DSP_DE, 0);
        chk("rst_hs",    DSP_HSYNC_X, 1);
        chk("rst_vs",    DSP_VSYNC_X, 1);
        chk("rst_rd",    fif.FIFO_RD, 0);
        chk("rst_clr",   fif.FIFO_CLR, 0);
        chk("rst_uf",    UNDERFLOW, 0);
        chk("rst_cnt",   UNDER_CNT, 0);
        DRST_X = 1'b1; HSYNC_X_IN = 1'b1; VSYNC_X_IN = 1'b1;

        // FSM / read strobe / flush / counter step table.
        for (int i = 0; i < 16; i++) begin
            @(negedge DCLK);
            DISP_ON = tbl[i].on; DSP_preDE = tbl[i].de;
            tb_empty = tbl[i].emp; VRSTART = tbl[i].vr;
            #1 chk($sformatf("tbl%0d_rd", i), fif.FIFO_RD, tbl[i].exp_rd);
            @(posedge DCLK);
            #1;
            chk($sformatf("tbl%0d_clr", i), fif.FIFO_CLR, tbl[i].exp_clr);
            chk($sformatf("tbl%0d_cnt", i), UNDER_CNT, tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_uf", i),  UNDERFLOW, tbl[i].exp_uf);
        end
        VRSTART = 1'b0; DSP_preDE = 1'b0;

        // Full line of 640 pixels, no underflow.
        use_model = 1'b1;
        do_reset();
        DISP_ON = 1'b1;
        load_fifo(640);
        run_line(640, 646, 640, -1, bad_rgb, bad_tim, clr_cnt, rd_ad);
        chk("full_rgb_bad", bad_rgb, 0);
        chk("full_tim_bad", bad_tim, 0);
        chk("full_clr",     clr_cnt, 0);
        chk("full_cnt",     UNDER_CNT, 0);

        // 100 pixels for a 640-pixel line: underflow then RESYNC.
        load_fifo(100);
        run_line(640, 646, 100, -1, bad_rgb, bad_tim, clr_cnt, rd_ad);
        chk("uf_rgb_bad", bad_rgb, 0);
        chk("uf_tim_bad", bad_tim, 0);
        chk("uf_clr",     clr_cnt, 1);
        chk("uf_cnt",     UNDER_CNT, 540);
        chk("uf_flag_pre", UNDERFLOW, 0);
        load_fifo(10);
        @(negedge DCLK);
        DSP_preDE = 1'b1;
        #1 chk("resync_no_rd", fif.FIFO_RD, 0);
        pulse_vr();
        chk("uf_flag_post", UNDERFLOW, 1);
        chk("uf_cnt_clr",   UNDER_CNT, 0);
        DSP_preDE = 1'b1;
        #1 chk("run_after_resync_rd", fif.FIFO_RD, 1);
        @(negedge DCLK);
        DSP_preDE = 1'b0;

        // Display switched off mid-line.
        do_reset();
        load_fifo(640);
        run_line(640, 646, 640, 200, bad_rgb, bad_tim, clr_cnt, rd_ad);
        chk("off_rgb_bad",  bad_rgb, 0);
        chk("off_tim_bad",  bad_tim, 0);
        chk("off_clr",      clr_cnt, 1);
        chk("off_rd_next",  rd_ad, 0);
        chk("off_cnt",      UNDER_CNT, 0);
        DISP_ON = 1'b1;

        // Short reset pulse between edges, mid-frame.
        do_reset();
        load_fifo(640);
        pulse_vr();
        DSP_preDE = 1'b1; HSYNC_X_IN = 1'b0; VSYNC_X_IN = 1'b0;
        repeat (50) @(negedge DCLK);
        chk("pre_rst_de",     DSP_DE, 1);
        chk("pre_rst_rgb_nz", ({DSP_R, DSP_G, DSP_B} != 24'h0), 1);
        @(posedge DCLK);
        #3 DRST_X = 1'b0;
        #0.5;
        chk("arst_rgb", {DSP_R, DSP_G, DSP_B}, 0);
        chk("arst_de",  DSP_DE, 0);
        chk("arst_hs",  DSP_HSYNC_X, 1);
        chk("arst_vs",  DSP_VSYNC_X, 1);
        chk("arst_rd",  fif.FIFO_RD, 0);
        #0.5 DRST_X = 1'b1;
        clr_cnt = 0;
        repeat (10) begin
            @(negedge DCLK);
            clr_cnt += int'(fif.FIFO_CLR);
        end
        chk("arst_no_clr", clr_cnt, 0);
        DSP_preDE = 1'b0; HSYNC_X_IN = 1'b1; VSYNC_X_IN = 1'b1;

        // Continuous starvation saturates the counter.
        do_reset();
        DISP_ON = 1'b1;
        pulse_vr();
        DSP_preDE = 1'b1;
        repeat (70000) @(negedge DCLK);
        DSP_preDE = 1'b0;
        @(negedge DCLK);
        chk("sat_cnt", UNDER_CNT, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/disp_pixout.md
DISP_PIXOUT -- requirements
Module: disp_pixout

Interface
REQ-001 Parameter PIPE_DLY, default 2, SHALL be the fixed input-to-output latency in DCLK cycles; only value 2 is supported.
REQ-002 Parameter PIXW, default 24, SHALL be the pixel width as {R[7:0],G[7:0],B[7:0]}.
REQ-003 DCLK  in  1  SHALL be the display pixel clock.
REQ-004 DRST_X  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 DISP_ON  in  1  SHALL be the display enable, quasi-static and synchronous to DCLK.
REQ-006 DSP_preDE  in  1  SHALL be the early data-enable from the sync generator.
REQ-007 HSYNC_X_IN, VSYNC_X_IN  in  1 each  SHALL be the sync generator's active-low syncs.
REQ-008 VRSTART  in  1  SHALL be the one-cycle frame-read start pulse.
REQ-009 FIFO_DOUT  in  PIXW  SHALL be pixel data, valid one cycle after FIFO_RD.
REQ-010 FIFO_EMPTY  in  1  SHALL be the pixel FIFO empty flag.
REQ-011 FIFO_RD  out  1  SHALL be the FIFO read strobe, one pixel per asserted cycle.
REQ-012 FIFO_CLR  out  1  SHALL be a one-cycle FIFO flush request.
REQ-013 DSP_R, DSP_G, DSP_B  out  8 each  SHALL be the registered pixel outputs.
REQ-014 DSP_DE, DSP_HSYNC_X, DSP_VSYNC_X  out  1 each  SHALL be the registered panel timing outputs.
REQ-015 UNDERFLOW  out  1  SHALL be a sticky flag meaning one or more pixels were starved in the previous frame.
REQ-016 UNDER_CNT  out  16  SHALL count starved pixels, saturating at 16'hFFFF.

Function
REQ-017 FSM states SHALL be WAIT (initial), RUN and RESYNC.
REQ-018 WAIT SHALL move to RUN on VRSTART=1 with DISP_ON=1.
REQ-019 RUN SHALL move to RESYNC when DSP_preDE=1 and FIFO_EMPTY=1 in the same cycle (underflow).
REQ-020 RESYNC SHALL move to RUN on VRSTART=1.
REQ-021 Any state SHALL move to WAIT when DISP_ON=0; this takes priority over all other transitions.
REQ-022 FIFO_RD SHALL equal (state==RUN) & DSP_preDE & ~FIFO_EMPTY, combinationally.
REQ-023 FIFO_CLR SHALL pulse for exactly one cycle on every entry to RESYNC and on every entry to WAIT from another state.
REQ-024 DSP_DE, DSP_HSYNC_X and DSP_VSYNC_X SHALL be DSP_preDE, HSYNC_X_IN and VSYNC_X_IN delayed by exactly PIPE_DLY cycles, independent of FSM state and DISP_ON.
REQ-025 RGB SHALL be registered from FIFO_DOUT so that the pixel read at cycle t appears at cycle t+2, aligned with DSP_DE.
REQ-026 RGB SHALL be 0 whenever delayed DE is 0, or the corresponding preDE cycle issued no read (WAIT, RESYNC or underflow).
REQ-027 Starved pixels SHALL be counted as cycles with DSP_preDE=1, DISP_ON=1, no read issued, and state RUN or RESYNC.
REQ-028 UNDER_CNT SHALL increment by 1 per starved pixel, saturate, and clear to 0 on VRSTART.
REQ-029 On VRSTART, UNDERFLOW SHALL load (UNDER_CNT!=0 | starved pixel in the same cycle).
REQ-030 When VRSTART and a starved pixel coincide, UNDER_CNT SHALL become 1.

Reset
REQ-031 With DRST_X=0, all outputs SHALL be 0 except DSP_HSYNC_X=1 and DSP_VSYNC_X=1, the FSM SHALL be WAIT, and the delay lines SHALL hold (DE=0, syncs=1).
REQ-032 Reset assertion SHALL act immediately; deassertion SHALL be synchronized to DCLK by the system reset block.
REQ-033 Reset asserted mid-frame SHALL discard pending pipeline pixels with no FIFO_CLR pulse.

Structure
REQ-034 PIPE_DLY, PIXW and the FSM state encoding SHALL live in the shared display package disp_pkg.
REQ-035 One sub-module, disp_dly (a parameterised N-stage shift register with a reset value), SHALL implement the DE and sync delay lines.

Verification
REQ-036 FIFO preloaded with 640 pixels 0x000001..0x000280, DISP_ON=1, VRSTART, 640-cycle preDE -> DSP_DE high for 640 cycles starting 2 cycles after preDE, RGB sequence 0x000001..0x000280, UNDER_CNT=0.
REQ-037 FIFO holds 100 pixels, preDE lasts 640 cycles -> 100 correct pixels then 540 black, one FIFO_CLR pulse, state RESYNC, UNDER_CNT=540, UNDERFLOW=1 after the next VRSTART.
REQ-038 Continuous underflow for 70000 preDE cycles -> UNDER_CNT holds 0xFFFF.
REQ-039 DISP_ON dropped mid-line -> FIFO_RD=0 next cycle, one FIFO_CLR pulse, RGB=0, syncs and DE still toggle with a 2-cycle delay.
REQ-040 DRST_X low for 1 ns between DCLK edges mid-frame -> outputs go to reset values before the next edge, no FIFO_CLR pulse.
REQ-041 VRSTART coincident with a starved pixel -> UNDER_CNT=1 and UNDERFLOW=1 on the next cycle.
